// File: rtl/i_fetch_mem_arbiter_pkg.sv
// Shared types for the instruction-fetch AXI read arbiter.
package i_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_DEM = 1'b0,
    OWN_PF  = 1'b1
  } owner_e;

  localparam int unsigned DEM_ID = 0;
  localparam int unsigned PF_ID  = 1;

  // A one-beat burst still needs a one-bit counter.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i_fetch_mem_arbiter_if.sv
// AXI read address/data channel bundle between the arbiter and memory.
interface i_fetch_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [ID_WIDTH-1:0]   arid;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [ID_WIDTH-1:0]   rid;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output araddr, arlen, arid, arvalid, rready,
    input  arready, rdata, rid, rlast, rvalid
  );

  modport slave (
    input  araddr, arlen, arid, arvalid, rready,
    output arready, rdata, rid, rlast, rvalid
  );
endinterface

// File: rtl/i_fetch_mem_arbiter.sv
// Instruction-side AXI read arbiter: demand fills beat prefetches, one
// fixed-length burst outstanding, beats routed to the burst owner.
module i_fetch_mem_arbiter
  import i_mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4,   // power of two, at most 16
  parameter int ID_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dem_req_valid,
  input  logic [ADDR_WIDTH-1:0] dem_req_addr,
  output logic                  dem_req_ready,
  input  logic                  pf_req_valid,
  input  logic [ADDR_WIDTH-1:0] pf_req_addr,
  output logic                  pf_req_ready,
  input  logic                  pf_flush,
  output logic [DATA_WIDTH-1:0] dem_rdata,
  output logic                  dem_rvalid,
  output logic                  dem_rlast,
  output logic [DATA_WIDTH-1:0] pf_rdata,
  output logic                  pf_rvalid,
  output logic                  pf_rlast,
  i_fetch_mem_arbiter_if.master axi,
  output logic                  protocol_err
);

  localparam int unsigned    CW       = cnt_width(BURST_LEN);
  localparam logic [CW-1:0]  LAST_CNT = CW'(BURST_LEN - 1);

  arb_state_e            state_q, state_d;
  owner_e                owner_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CW-1:0]         cnt_q;
  logic                  discard_q;
  logic                  err_q;

  logic                  grant_dem, grant_pf;
  logic                  ar_hs, beat, cnt_last;
  logic [ID_WIDTH-1:0]   own_id;

  assign own_id   = (owner_q == OWN_PF) ? ID_WIDTH'(PF_ID) : ID_WIDTH'(DEM_ID);
  assign ar_hs    = (state_q == ADDR) && axi.arready;
  assign beat     = (state_q == DATA) && axi.rvalid;
  assign cnt_last = (cnt_q == LAST_CNT);

  // Next state, grant decision and AXI channel outputs
  always_comb begin
    state_d     = state_q;
    grant_dem   = 1'b0;
    grant_pf    = 1'b0;
    axi.arvalid = 1'b0;
    axi.araddr  = '0;
    axi.arlen   = '0;
    axi.arid    = '0;
    axi.rready  = 1'b0;
    case (state_q)
      IDLE: begin
        // Demand has strict priority; a waiting prefetch may starve.
        if (dem_req_valid) begin
          grant_dem = 1'b1;
          state_d   = ADDR;
        end else if (pf_req_valid) begin
          grant_pf  = 1'b1;
          state_d   = ADDR;
        end
      end
      ADDR: begin
        // Held stable until arready; a flush never withdraws the request.
        axi.arvalid = 1'b1;
        axi.araddr  = addr_q;
        axi.arlen   = 8'(BURST_LEN - 1);
        axi.arid    = own_id;
        if (axi.arready) state_d = DATA;
      end
      DATA: begin
        axi.rready = 1'b1;
        if (axi.rvalid && cnt_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Owner and line address captured at grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_DEM;
      addr_q  <= '0;
    end else if (grant_dem) begin
      owner_q <= OWN_DEM;
      addr_q  <= dem_req_addr;
    end else if (grant_pf) begin
      owner_q <= OWN_PF;
      addr_q  <= pf_req_addr;
    end
  end

  // Beat counter; routing and rlast follow this, not the bus rlast
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt_q <= '0;
    else if (state_q != DATA)   cnt_q <= '0;
    else if (beat)              cnt_q <= cnt_last ? '0 : cnt_q + 1'b1;
  end

  // Discard flag: a flushed prefetch burst is still drained, just hidden
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  discard_q <= 1'b0;
    else if (state_q == IDLE)                    discard_q <= 1'b0;
    else if (pf_flush && owner_q == OWN_PF)      discard_q <= 1'b1;
  end

  // Sticky protocol error on wrong RID or misplaced/missing RLAST
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_q <= 1'b0;
    else if (beat && ((axi.rid != own_id) || (axi.rlast != cnt_last)))
      err_q <= 1'b1;
  end

  // Requester-side outputs; beats pass through with zero latency
  always_comb begin
    dem_req_ready = ar_hs && (owner_q == OWN_DEM);
    pf_req_ready  = ar_hs && (owner_q == OWN_PF);
    dem_rvalid    = beat && (owner_q == OWN_DEM);
    pf_rvalid     = beat && (owner_q == OWN_PF) && !discard_q;
    dem_rlast     = dem_rvalid && cnt_last;
    pf_rlast      = pf_rvalid && cnt_last;
    dem_rdata     = dem_rvalid ? axi.rdata : '0;
    pf_rdata      = pf_rvalid ? axi.rdata : '0;
    protocol_err  = err_q;
  end

endmodule

// File: tb/tb_i_fetch_mem_arbiter.sv
// Directed + randomized bench for i_fetch_mem_arbiter with a memory model.
module tb_i_fetch_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BL = 4;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          dem_req_valid, pf_req_valid, pf_flush;
  logic [AW-1:0] dem_req_addr, pf_req_addr;
  logic          dem_req_ready, pf_req_ready;
  logic [DW-1:0] dem_rdata, pf_rdata;
  logic          dem_rvalid, dem_rlast, pf_rvalid, pf_rlast, protocol_err;

  i_fetch_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) axi ();

  i_fetch_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .dem_req_valid(dem_req_valid), .dem_req_addr(dem_req_addr), .dem_req_ready(dem_req_ready),
    .pf_req_valid(pf_req_valid), .pf_req_addr(pf_req_addr), .pf_req_ready(pf_req_ready),
    .pf_flush(pf_flush),
    .dem_rdata(dem_rdata), .dem_rvalid(dem_rvalid), .dem_rlast(dem_rlast),
    .pf_rdata(pf_rdata), .pf_rvalid(pf_rvalid), .pf_rlast(pf_rlast),
    .axi(axi), .protocol_err(protocol_err)
  );

  int          n_pass = 0;
  int          n_total = 0;
  logic        err_exp = 1'b0;
  logic [31:0] seed;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Memory contents: a fixed scramble of line address and beat index
  function automatic logic [31:0] mem_word(input logic [31:0] a, input int b);
    return (a + 32'(b) * 32'd4) ^ seed ^ (32'(b) * 32'h9E37_79B9);
  endfunction

  function automatic logic [AW-1:0] rand_line();
    return AW'($urandom) & ~AW'(BL * 4 - 1);
  endfunction

  task automatic check_quiet(input string tag);
    chk({tag, "_arvalid"}, axi.arvalid, 0);
    chk({tag, "_araddr"}, axi.araddr, 0);
    chk({tag, "_arlen"}, axi.arlen, 0);
    chk({tag, "_rready"}, axi.rready, 0);
    chk({tag, "_rvalid"}, {dem_rvalid, pf_rvalid, dem_rlast, pf_rlast}, 0);
    chk({tag, "_rdata"}, {dem_rdata, pf_rdata}, 0);
    chk({tag, "_ready"}, {dem_req_ready, pf_req_ready}, 0);
    chk({tag, "_err"}, protocol_err, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    err_exp = 1'b0;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Wait for AR (expected two sampled cycles after the request appears),
  // optionally stall arready, then handshake.
  task automatic addr_phase(input logic [AW-1:0] ea, input int own, input int stall);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk("idle_arvalid", axi.arvalid, 0);
        chk("idle_rready", axi.rready, 0);
      end
    end while (!axi.arvalid && n < 20);
    chk("ar_latency", n, 2);
    for (int s = 0; s <= stall; s++) begin
      chk("araddr", axi.araddr, ea);
      chk("arlen", axi.arlen, BL - 1);
      chk("arid", axi.arid, own);
      chk("arvalid", axi.arvalid, 1);
      if (s < stall) begin
        chk("ready_stall", {dem_req_ready, pf_req_ready}, 0);
        @(negedge clk);
      end
    end
    axi.arready = 1'b1;
    #1;
    chk("dem_req_ready", dem_req_ready, own == 0);
    chk("pf_req_ready", pf_req_ready, own == 1);
    @(posedge clk); #1;
    axi.arready = 1'b0;
    if (own == 0) dem_req_valid = 1'b0;
    else          pf_req_valid = 1'b0;
  endtask

  // Deliver one burst; returns at posedge+1 after the last beat.
  task automatic data_phase(input int own, input logic [AW-1:0] a, input int bad_rid_at,
                            input int bad_last_at, input int flush_at, input int abort_at);
    logic disc = 1'b0;
    logic bad;
    for (int b = 0; b < BL; b++) begin
      int gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(negedge clk);
        chk("gap_rready", axi.rready, 1);
        chk("gap_rvalid", {dem_rvalid, pf_rvalid}, 0);
        @(posedge clk); #1;
      end
      bad = (b == bad_rid_at) || (b == bad_last_at);
      axi.rvalid = 1'b1;
      axi.rdata  = mem_word(a, b);
      axi.rid    = IW'((b == bad_rid_at) ? (own ^ 1) : own);
      axi.rlast  = (b == BL - 1) ^ (b == bad_last_at);
      @(negedge clk);
      if (b == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_quiet("abort");
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
        err_exp    = 1'b0;
        return;
      end
      chk("beat_rready", axi.rready, 1);
      chk("dem_rvalid", dem_rvalid, own == 0);
      chk("pf_rvalid", pf_rvalid, (own == 1) && !disc);
      if (own == 0) begin
        chk("dem_rdata", dem_rdata, mem_word(a, b));
        chk("dem_rlast", dem_rlast, b == BL - 1);
      end else if (!disc) begin
        chk("pf_rdata", pf_rdata, mem_word(a, b));
        chk("pf_rlast", pf_rlast, b == BL - 1);
      end
      chk("ready_pulse", {dem_req_ready, pf_req_ready}, 0);
      chk("err_pre", protocol_err, err_exp);
      @(posedge clk); #1;
      if (bad) err_exp = 1'b1;
      axi.rvalid = 1'b0;
      axi.rlast  = 1'b0;
      axi.rid    = '0;
      if (b == flush_at) begin
        pf_flush = 1'b1;
        @(negedge clk);
        chk("flush_rready", axi.rready, 1);
        @(posedge clk); #1;
        pf_flush = 1'b0;
        if (own == 1) disc = 1'b1;
      end
    end
    chk("err_post", protocol_err, err_exp);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] da, pa;
    int            hd, hp;
    seed = $urandom;
    dem_req_valid = 1'b0; dem_req_addr = '0;
    pf_req_valid  = 1'b0; pf_req_addr  = '0;
    pf_flush      = 1'b0;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rid = '0; axi.rlast = 1'b0;

    do_reset();

    // Demand only at 0x100
    dem_req_valid = 1'b1; dem_req_addr = 32'h100;
    addr_phase(32'h100, 0, 0);
    data_phase(0, 32'h100, -1, -1, -1, -1);

    // Demand and prefetch together: demand first, prefetch after one IDLE
    dem_req_valid = 1'b1; dem_req_addr = 32'h200;
    pf_req_valid  = 1'b1; pf_req_addr  = 32'h300;
    addr_phase(32'h200, 0, 1);
    data_phase(0, 32'h200, -1, -1, -1, -1);
    addr_phase(32'h300, 1, 0);
    data_phase(1, 32'h300, -1, -1, -1, -1);

    // arready stalled for 5 cycles
    dem_req_valid = 1'b1; dem_req_addr = 32'h440;
    addr_phase(32'h440, 0, 5);
    data_phase(0, 32'h440, -1, -1, -1, -1);

    // Flush in IDLE has no effect on the following prefetch
    pf_flush = 1'b1; @(posedge clk); #1; pf_flush = 1'b0;
    pf_req_valid = 1'b1; pf_req_addr = 32'h5C0;
    addr_phase(32'h5C0, 1, 0);
    data_phase(1, 32'h5C0, -1, -1, -1, -1);

    // Prefetch flushed after beat 1, then a normal demand
    pf_req_valid = 1'b1; pf_req_addr = 32'h600;
    addr_phase(32'h600, 1, 2);
    data_phase(1, 32'h600, -1, -1, 1, -1);
    dem_req_valid = 1'b1; dem_req_addr = 32'h700;
    addr_phase(32'h700, 0, 0);
    data_phase(0, 32'h700, -1, -1, 0, -1);   // flush during demand: ignored

    // Randomized mixes of requests
    for (int it = 0; it < 8; it++) begin
      hd = $urandom_range(0, 1);
      hp = (hd == 0) ? 1 : $urandom_range(0, 1);
      da = rand_line(); pa = rand_line();
      dem_req_valid = hd[0]; dem_req_addr = da;
      pf_req_valid  = hp[0]; pf_req_addr  = pa;
      if (hd != 0) begin
        addr_phase(da, 0, $urandom_range(0, 3));
        data_phase(0, da, -1, -1, -1, -1);
      end
      if (hp != 0) begin
        addr_phase(pa, 1, $urandom_range(0, 3));
        data_phase(1, pa, -1, -1, ($urandom_range(0, 1) != 0) ? $urandom_range(0, BL - 2) : -1, -1);
      end
    end

    // Wrong RID during a demand burst; error is sticky across bursts
    dem_req_valid = 1'b1; dem_req_addr = 32'h800;
    addr_phase(32'h800, 0, 0);
    data_phase(0, 32'h800, 2, -1, -1, -1);
    pf_req_valid = 1'b1; pf_req_addr = 32'h840;
    addr_phase(32'h840, 1, 0);
    data_phase(1, 32'h840, -1, -1, -1, -1);
    do_reset();

    // Early RLAST on beat 1
    dem_req_valid = 1'b1; dem_req_addr = 32'h900;
    addr_phase(32'h900, 0, 0);
    data_phase(0, 32'h900, -1, 1, -1, -1);
    chk("err_sticky", protocol_err, 1);

    // Reset during beat 2, then no AR until a new request
    dem_req_valid = 1'b1; dem_req_addr = 32'hA00;
    addr_phase(32'hA00, 0, 0);
    data_phase(0, 32'hA00, -1, -1, -1, 2);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_reset_arvalid", axi.arvalid, 0);
      chk("post_reset_err", protocol_err, 0);
    end
    @(posedge clk); #1;
    dem_req_valid = 1'b1; dem_req_addr = 32'hB00;
    addr_phase(32'hB00, 0, 0);
    data_phase(0, 32'hB00, -1, -1, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
